// File: rtl/score_digit_src_if.sv
// Game-control inputs and digit-display outputs shared between the score
// source and its consumer.
interface score_digit_src_if;
  logic       inc;
  logic       game_over;
  logic       new_game;
  logic       show_best;
  logic [1:0] scan_sel;
  logic [3:0] digit_4;
  logic [3:0] digit_3;
  logic [3:0] digit_2;
  logic [3:0] digit_1;
  logic       playing;

  modport master (
    output inc, game_over, new_game, show_best,
    input  scan_sel, digit_4, digit_3, digit_2, digit_1, playing
  );

  modport slave (
    input  inc, game_over, new_game, show_best,
    output scan_sel, digit_4, digit_3, digit_2, digit_1, playing
  );
endinterface

// File: rtl/score_digit_src.sv
// Score/best-score keeper and game FSM feeding the 4-digit seven-segment scan
// multiplexer: BCD digits with leading-zero blanking plus the scan select.
module score_digit_src #(
  parameter int unsigned SCAN_DIV_BITS = 17,
  parameter logic [3:0]  BLANK_CODE    = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  score_digit_src_if.slave  bus
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SCORE_W = 4 * DIGIT_W;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   best_q, best_d;
  logic [SCORE_W-1:0]   score_inc;
  logic [SCORE_W-1:0]   shown;
  logic [SCAN_DIV_BITS-1:0] scan_cnt_q;
  logic [1:0]           scan_sel_q;
  logic [DIGIT_W-1:0]   dig4_q, dig3_q, dig2_q, dig1_q;
  logic [DIGIT_W-1:0]   dig4_d, dig3_d, dig2_d, dig1_d;
  logic                 playing_q;
  logic                 carry;

  // State, score and best registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      best_q  <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      best_q  <= best_d;
    end
  end

  // Saturating BCD increment; the carry ripples through all four digits
  always_comb begin
    score_inc = score_q;
    carry     = (score_q != SCORE_MAX);
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (score_q[i*4 +: 4] == 4'd9) begin
          score_inc[i*4 +: 4] = 4'd0;
        end else begin
          score_inc[i*4 +: 4] = score_q[i*4 +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Next-state logic; in PLAY new_game beats game_over beats inc
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    best_d  = best_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.new_game) begin
          state_d = ST_PLAY;
          score_d = '0;
        end
      end
      ST_PLAY: begin
        if (bus.new_game) begin
          score_d = '0;
        end else if (bus.game_over) begin
          state_d = ST_OVER;
          if (score_q > best_q) best_d = score_q;
        end else if (bus.inc) begin
          score_d = score_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Display source selection and leading-zero blanking
  always_comb begin
    shown  = (bus.show_best || (state_q == ST_IDLE)) ? best_q : score_q;
    dig4_d = shown[15:12];
    dig3_d = shown[11:8];
    dig2_d = shown[7:4];
    dig1_d = shown[3:0];
    if (shown[15:12] == 4'd0) begin
      dig4_d = BLANK_CODE;
      if (shown[11:8] == 4'd0) begin
        dig3_d = BLANK_CODE;
        if (shown[7:4] == 4'd0) dig2_d = BLANK_CODE;
      end
    end
  end

  // Free-running scan divider and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      scan_sel_q <= 2'b00;
      dig4_q     <= BLANK_CODE;
      dig3_q     <= BLANK_CODE;
      dig2_q     <= BLANK_CODE;
      dig1_q     <= 4'h0;
      playing_q  <= 1'b0;
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_DIV_BITS'(1);
      scan_sel_q <= scan_cnt_q[SCAN_DIV_BITS-1 -: 2];
      dig4_q     <= dig4_d;
      dig3_q     <= dig3_d;
      dig2_q     <= dig2_d;
      dig1_q     <= dig1_d;
      playing_q  <= (state_q == ST_PLAY);
    end
  end

  assign bus.scan_sel = scan_sel_q;
  assign bus.digit_4  = dig4_q;
  assign bus.digit_3  = dig3_q;
  assign bus.digit_2  = dig2_q;
  assign bus.digit_1  = dig1_q;
  assign bus.playing  = playing_q;

endmodule

// File: tb/tb_score_digit_src.sv
// Bench for score_digit_src: decimal-level reference model checked every
// cycle, plus directed scenarios with literal expected digit codes.
module tb_score_digit_src;

  localparam int unsigned SDB = 4;

  logic clk;
  logic rst;
  score_digit_src_if bus ();

  score_digit_src #(
    .SCAN_DIV_BITS (SDB),
    .BLANK_CODE    (4'hF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: score/best as plain integers, mode 0=idle 1=play 2=over
  int          m_score, m_best, m_cnt, m_mode;
  logic [15:0] exp_dig;
  logic [1:0]  exp_scan;
  logic        exp_play;
  bit          valid = 1'b0;

  function automatic logic [15:0] disp(input int v);
    logic [3:0] th, h, t, o;
    th = 4'(v / 1000);
    h  = 4'((v / 100) % 10);
    t  = 4'((v / 10) % 10);
    o  = 4'(v % 10);
    return {(v >= 1000) ? th : 4'hF, (v >= 100) ? h : 4'hF,
            (v >= 10) ? t : 4'hF, o};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_score  = 0;
      m_best   = 0;
      m_cnt    = 0;
      m_mode   = 0;
      exp_dig  = 16'hFFF0;
      exp_scan = 2'b00;
      exp_play = 1'b0;
      valid    = 1'b1;
    end else begin
      exp_dig  = disp((bus.show_best || m_mode == 0) ? m_best : m_score);
      exp_play = (m_mode == 1);
      exp_scan = 2'(m_cnt / (1 << (SDB - 2)));
      m_cnt    = (m_cnt + 1) % (1 << SDB);
      if (m_mode == 1) begin
        if (bus.new_game) m_score = 0;
        else if (bus.game_over) begin
          if (m_score > m_best) m_best = m_score;
          m_mode = 2;
        end else if (bus.inc && m_score < 9999) m_score = m_score + 1;
      end else if (bus.new_game) begin
        m_mode  = 1;
        m_score = 0;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (valid) begin
      n_checks++;
      if ({bus.digit_4, bus.digit_3, bus.digit_2, bus.digit_1} !== exp_dig) begin
        n_fail++;
        $display("FAIL model_digits t=%0t: got %h expected %h", $time,
                 {bus.digit_4, bus.digit_3, bus.digit_2, bus.digit_1}, exp_dig);
      end
      n_checks++;
      if (bus.scan_sel !== exp_scan) begin
        n_fail++;
        $display("FAIL model_scan t=%0t: got %b expected %b", $time, bus.scan_sel, exp_scan);
      end
      n_checks++;
      if (bus.playing !== exp_play) begin
        n_fail++;
        $display("FAIL model_playing t=%0t: got %b expected %b", $time, bus.playing, exp_play);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_incs(input int n);
    bus.inc = 1'b1;
    step(n);
    bus.inc = 1'b0;
  endtask

  task automatic pulse_new_game();
    bus.new_game = 1'b1;
    step(1);
    bus.new_game = 1'b0;
  endtask

  task automatic pulse_game_over();
    bus.game_over = 1'b1;
    step(1);
    bus.game_over = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic check_digits(input string name, input logic [15:0] exp);
    n_checks++;
    if ({bus.digit_4, bus.digit_3, bus.digit_2, bus.digit_1} !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name,
               {bus.digit_4, bus.digit_3, bus.digit_2, bus.digit_1}, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  logic [1:0] scan_exp [18];

  initial begin
    scan_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    rst           = 1'b1;
    bus.inc       = 1'b0;
    bus.game_over = 1'b0;
    bus.new_game  = 1'b0;
    bus.show_best = 1'b0;
    step(2);
    check_digits("reset_digits", 16'hFFF0);
    check_bit("reset_playing", bus.playing, 1'b0);
    check_bit("reset_scan0", bus.scan_sel[0], 1'b0);
    check_bit("reset_scan1", bus.scan_sel[1], 1'b0);

    // Scan select walk from reset: edge k shows ((k-1) mod 16) / 4
    rst = 1'b0;
    for (int k = 1; k < 18; k++) begin
      step(1);
      n_checks++;
      if (bus.scan_sel !== scan_exp[k]) begin
        n_fail++;
        $display("FAIL scan_walk k=%0d: got %b expected %b", k, bus.scan_sel, scan_exp[k]);
      end
    end

    // inc ignored in IDLE
    do_incs(3);
    step(2);
    check_digits("idle_inc_ignored", 16'hFFF0);

    pulse_new_game();
    do_incs(12);
    step(2);
    check_digits("score_12", 16'hFF12);
    check_bit("playing_12", bus.playing, 1'b1);

    pulse_new_game();
    do_incs(99);
    step(2);
    check_digits("score_99", 16'hFF99);
    do_incs(1);
    step(2);
    check_digits("score_100", 16'hF100);

    pulse_new_game();
    do_incs(9998);
    step(2);
    check_digits("score_9998", 16'h9998);
    do_incs(3);
    step(2);
    check_digits("score_9999_sat", 16'h9999);

    // Best tracking
    do_reset();
    pulse_new_game();
    do_incs(30);
    pulse_game_over();
    step(2);
    check_bit("over_playing", bus.playing, 1'b0);
    check_digits("over_shows_score", 16'hFF30);
    pulse_new_game();
    do_incs(45);
    pulse_game_over();
    bus.show_best = 1'b1;
    step(2);
    check_digits("best_45", 16'hFF45);
    bus.show_best = 1'b0;
    pulse_new_game();
    do_incs(20);
    pulse_game_over();
    step(2);
    check_digits("over_score_20", 16'hFF20);
    bus.show_best = 1'b1;
    step(2);
    check_digits("best_stays_45", 16'hFF45);
    bus.show_best = 1'b0;
    pulse_new_game();
    do_incs(3);
    bus.show_best = 1'b1;
    step(2);
    check_digits("show_best_in_play", 16'hFF45);
    check_bit("show_best_playing", bus.playing, 1'b1);
    bus.show_best = 1'b0;

    // Same-cycle game_over + inc: inc dropped, pre-increment score compared
    do_reset();
    pulse_new_game();
    do_incs(7);
    bus.game_over = 1'b1;
    bus.inc       = 1'b1;
    step(1);
    bus.game_over = 1'b0;
    bus.inc       = 1'b0;
    step(2);
    check_digits("go_inc_score", 16'hFFF7);
    bus.show_best = 1'b1;
    step(2);
    check_digits("go_inc_best", 16'hFFF7);
    bus.show_best = 1'b0;

    // Same-cycle new_game + game_over in PLAY: restart wins
    pulse_new_game();
    do_incs(5);
    bus.new_game  = 1'b1;
    bus.game_over = 1'b1;
    step(1);
    bus.new_game  = 1'b0;
    bus.game_over = 1'b0;
    step(2);
    check_digits("ng_go_score", 16'hFFF0);
    check_bit("ng_go_playing", bus.playing, 1'b1);
    bus.show_best = 1'b1;
    step(2);
    check_digits("ng_go_best", 16'hFFF7);
    bus.show_best = 1'b0;

    // inc ignored in OVER
    do_incs(4);
    pulse_game_over();
    do_incs(3);
    step(2);
    check_digits("over_inc_ignored", 16'hFFF4);

    // Reset mid-game discards score and best
    do_reset();
    pulse_new_game();
    do_incs(500);
    pulse_game_over();
    pulse_new_game();
    do_incs(321);
    step(2);
    check_digits("score_321", 16'hF321);
    rst = 1'b1;
    step(1);
    check_digits("midreset_digits", 16'hFFF0);
    check_bit("midreset_playing", bus.playing, 1'b0);
    check_bit("midreset_scan", |bus.scan_sel, 1'b0);
    rst = 1'b0;
    bus.show_best = 1'b1;
    step(2);
    check_digits("midreset_best_cleared", 16'hFFF0);
    bus.show_best = 1'b0;

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
